// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
//   Multi-cycle control unit for the CPU. It reads Opcode/Flags from the
//   datapath, drives every datapath control input, and owns the external
//   memory strobes. Instructions run FETCH_A -> FETCH_D -> EXEC
//   [-> MEM_RD | MEM_WR] -> FETCH_A.
//
// Ports
//   Clock        in   rising-edge clock
//   nReset       in   asynchronous active-low reset
//   Opcode[9:0]  in   {IR[15:9], IR[2:0]}
//                     [9:8] class, [7:4] ALU function, [2:0] branch condition
//   Flags[3:0]   in   {Z, C, V, N}
//   nWait        in   memory ready (0 = stall the current memory phase)
//   AluOp[3:0]   out  ALU function
//   Op1Sel[1:0]  out  ALU operand-1 source (always 0 in this revision)
//   Op2Sel       out  0 = register, 1 = immediate
//   PcSel[1:0]   out  0 = Pc1, 1 = PcImm, 2 = PcLr
//   Rw, WdSel, AluEn, SpEn, SpWe, LrEn, LrWe, LrSel, PcWe, PcEn, IrWe,
//   ImmSel, RegWe, MemEn, Rs1Sel, CFlag   out  datapath controls
//   Ale          out  SysBus carries an address this cycle
//   nOE, nWE     out  memory read / write strobes, active low
//   BusErr       out  one-cycle pulse after a memory-phase stall timeout
//   state_dbg    out  current FSM state (debug visibility)
//
// Memory handshake: a memory phase (FETCH_D, MEM_RD, MEM_WR) presents its
// strobe and completes on the first cycle with nWait=1; that cycle is the
// only one in which the phase's write enable (IrWe/PcWe or RegWe) is issued.
// Each nWait=0 cycle holds the phase for one more cycle. WAIT_TIMEOUT
// consecutive nWait=0 cycles abandon the phase: BusErr pulses in the next
// cycle and the FSM refetches from the unadvanced PC.
module cpu_control_fsm #(
  parameter int unsigned WAIT_TIMEOUT = 15  // 1..16, 4-bit stall counter
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [9:0] Opcode,
  input  logic [3:0] Flags,
  input  logic       nWait,
  output logic [3:0] AluOp,
  output logic [1:0] Op1Sel,
  output logic       Op2Sel,
  output logic [1:0] PcSel,
  output logic       Rw,
  output logic       WdSel,
  output logic       AluEn,
  output logic       SpEn,
  output logic       SpWe,
  output logic       LrEn,
  output logic       LrWe,
  output logic       LrSel,
  output logic       PcWe,
  output logic       PcEn,
  output logic       IrWe,
  output logic       ImmSel,
  output logic       RegWe,
  output logic       MemEn,
  output logic       Rs1Sel,
  output logic       CFlag,
  output logic       Ale,
  output logic       nOE,
  output logic       nWE,
  output logic       BusErr,
  output logic [2:0] state_dbg
);

  localparam logic [1:0] PC1    = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_LR  = 2'd2;

  localparam logic [3:0] STALL_LAST = 4'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_D = 3'd1,
    EXEC    = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] stall_cnt;
  logic       cflag_q;
  logic       bus_err_q;
  logic       br_taken;

  // Opcode[3] (IR bit 9... the gap between function and condition fields)
  // carries nothing for this unit.
  logic unused_opcode_bit;
  assign unused_opcode_bit = Opcode[3];

  assign state_dbg = state;
  assign CFlag     = cflag_q;
  assign BusErr    = bus_err_q;
  assign SpEn      = 1'b0;
  assign SpWe      = 1'b0;

  // Branch condition, Flags = {Z, C, V, N}.
  always_comb begin
    br_taken = 1'b0;
    case (Opcode[2:0])
      3'b000: br_taken = 1'b1;
      3'b001: br_taken = Flags[3];
      3'b010: br_taken = ~Flags[3];
      3'b011: br_taken = Flags[2];
      3'b100: br_taken = ~Flags[2];
      3'b101: br_taken = Flags[0];
      3'b110: br_taken = Flags[1];
      default: br_taken = 1'b0;
    endcase
  end

  // State, stall counter and the registered status outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= FETCH_A;
      stall_cnt <= 4'd0;
      cflag_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        FETCH_A: state <= FETCH_D;
        FETCH_D, MEM_RD, MEM_WR: begin
          if (nWait) begin
            stall_cnt <= 4'd0;
            state     <= (state == FETCH_D) ? EXEC : FETCH_A;
          end else if (stall_cnt == STALL_LAST) begin
            stall_cnt <= 4'd0;
            bus_err_q <= 1'b1;
            state     <= FETCH_A;
          end else begin
            stall_cnt <= stall_cnt + 4'd1;
          end
        end
        EXEC: begin
          cflag_q <= Flags[2];
          if (Opcode[9:8] == 2'b10) state <= Opcode[7] ? MEM_WR : MEM_RD;
          else                      state <= FETCH_A;
        end
        default: state <= FETCH_A;
      endcase
    end
  end

  // Control decode. The IR is loaded on the same edge that enters EXEC, so
  // the EXEC controls must follow the live Opcode rather than a value
  // captured on that edge; likewise the memory-phase write enables follow
  // the live nWait. Outputs are forced idle while nReset is low so the
  // strobes release within the reset cycle itself.
  always_comb begin
    AluOp  = 4'd0;
    Op1Sel = 2'd0;
    Op2Sel = 1'b0;
    PcSel  = PC1;
    Rw     = 1'b0;
    WdSel  = 1'b0;
    AluEn  = 1'b0;
    LrEn   = 1'b0;
    LrWe   = 1'b0;
    LrSel  = 1'b0;
    PcWe   = 1'b0;
    PcEn   = 1'b0;
    IrWe   = 1'b0;
    ImmSel = 1'b0;
    RegWe  = 1'b0;
    MemEn  = 1'b0;
    Rs1Sel = 1'b0;
    Ale    = 1'b0;
    nOE    = 1'b1;
    nWE    = 1'b1;
    if (nReset) begin
      case (state)
        FETCH_A: begin
          PcEn = 1'b1;
          Ale  = 1'b1;
        end
        FETCH_D: begin
          nOE   = 1'b0;
          MemEn = 1'b1;
          if (nWait) begin
            IrWe = 1'b1;
            PcWe = 1'b1;
          end
        end
        EXEC: begin
          case (Opcode[9:8])
            2'b00, 2'b01: begin
              AluOp  = Opcode[7:4];
              AluEn  = 1'b1;
              RegWe  = 1'b1;
              Op2Sel = Opcode[8];
              ImmSel = Opcode[8];
            end
            2'b10: begin
              // Effective address = base register + immediate.
              AluEn  = 1'b1;
              Op2Sel = 1'b1;
              ImmSel = 1'b1;
              Ale    = 1'b1;
            end
            default: begin
              case (Opcode[7:6])
                2'b00: begin
                  if (br_taken) begin
                    PcSel = PC_IMM;
                    PcWe  = 1'b1;
                  end
                end
                2'b01: begin
                  // LR latches the pre-branch PC on the same edge.
                  LrSel = 1'b1;
                  LrWe  = 1'b1;
                  PcSel = PC_IMM;
                  PcWe  = 1'b1;
                end
                2'b10: begin
                  PcSel = PC_LR;
                  PcWe  = 1'b1;
                end
                default: ;
              endcase
            end
          endcase
        end
        MEM_RD: begin
          nOE   = 1'b0;
          MemEn = 1'b1;
          WdSel = 1'b1;
          RegWe = nWait;
        end
        MEM_WR: begin
          nWE    = 1'b0;
          Rw     = 1'b1;
          Rs1Sel = 1'b1;
          AluEn  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // At most one SysBus driver per cycle.
  a_one_bus_driver: assert property (@(posedge Clock) disable iff (!nReset)
    $onehot0({PcEn, MemEn, AluEn, LrEn}));

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] op1_sel;
    logic       op2_sel;
    logic [1:0] pc_sel;
    logic rw, wd_sel, alu_en, sp_en, sp_we, lr_en, lr_we, lr_sel;
    logic pc_we, pc_en, ir_we, imm_sel, reg_we, mem_en, rs1_sel;
    logic cflag, ale, n_oe, n_we, bus_err;
  } ctl_t;

  localparam int W = $bits(ctl_t);

  // ---------------- clock / reset / DUT ----------------
  logic       Clock = 1'b0;
  logic       nReset;
  logic [9:0] Opcode;
  logic [3:0] Flags;
  logic       nWait;
  logic [3:0] AluOp;
  logic [1:0] Op1Sel, PcSel;
  logic       Op2Sel, Rw, WdSel, AluEn, SpEn, SpWe, LrEn, LrWe, LrSel;
  logic       PcWe, PcEn, IrWe, ImmSel, RegWe, MemEn, Rs1Sel, CFlag;
  logic       Ale, nOE, nWE, BusErr;
  logic [2:0] state_dbg;

  always #5 Clock = ~Clock;

  cpu_control_fsm #(.WAIT_TIMEOUT(15)) dut (
    .Clock(Clock), .nReset(nReset), .Opcode(Opcode), .Flags(Flags),
    .nWait(nWait), .AluOp(AluOp), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel),
    .PcSel(PcSel), .Rw(Rw), .WdSel(WdSel), .AluEn(AluEn), .SpEn(SpEn),
    .SpWe(SpWe), .LrEn(LrEn), .LrWe(LrWe), .LrSel(LrSel), .PcWe(PcWe),
    .PcEn(PcEn), .IrWe(IrWe), .ImmSel(ImmSel), .RegWe(RegWe),
    .MemEn(MemEn), .Rs1Sel(Rs1Sel), .CFlag(CFlag), .Ale(Ale), .nOE(nOE),
    .nWE(nWE), .BusErr(BusErr), .state_dbg(state_dbg)
  );

  ctl_t obs;
  assign obs = {AluOp, Op1Sel, Op2Sel, PcSel, Rw, WdSel, AluEn, SpEn, SpWe,
                LrEn, LrWe, LrSel, PcWe, PcEn, IrWe, ImmSel, RegWe, MemEn,
                Rs1Sel, CFlag, Ale, nOE, nWE, BusErr};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           nw_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  // Reference-model state: carried CFlag and a pending BusErr pulse.
  logic cflag_m  = 1'b0;
  logic pend_err = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t idle_vec();
    ctl_t v;
    v       = '0;
    v.n_oe  = 1'b1;
    v.n_we  = 1'b1;
    v.cflag = cflag_m;
    return v;
  endfunction

  task automatic push(input ctl_t v, input bit nw);
    exp_q.push_back(v);
    nw_q.push_back(nw);
  endtask

  function automatic bit cond_true(input logic [2:0] cc, input logic [3:0] fl);
    logic z, c, v, n;
    {z, c, v, n} = fl;
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return n;
      3'd6: return v;
      default: return 1'b0;
    endcase
  endfunction

  // Builds the full cycle trace of one instruction from the timing rules:
  // address cycle, fs fetch stalls, fetch-data cycle, execute, then for
  // loads/stores ms memory stalls and a completion cycle. A stall count of
  // 15 is a timeout: the phase ends there and the next fetch shows BusErr.
  // Then drives it cycle by cycle (stopping after 'cut' cycles if nonzero).
  task automatic run_instr(input string name, input logic [9:0] op,
                           input logic [3:0] fl, input int fs, input int ms,
                           input int cut);
    ctl_t e;
    int   cyc;
    exp_q.delete();
    nw_q.delete();

    e = idle_vec(); e.pc_en = 1; e.ale = 1; e.bus_err = pend_err;
    pend_err = 1'b0;
    push(e, 1'($urandom_range(0, 1)));
    for (int k = 0; k < ((fs >= 15) ? 15 : fs); k++) begin
      e = idle_vec(); e.n_oe = 0; e.mem_en = 1; push(e, 0);
    end
    if (fs >= 15) pend_err = 1'b1;
    else begin
      e = idle_vec(); e.n_oe = 0; e.mem_en = 1; e.ir_we = 1; e.pc_we = 1;
      push(e, 1);
      e = idle_vec();
      case (op[9:8])
        2'b00, 2'b01: begin
          e.alu_op = op[7:4]; e.alu_en = 1; e.reg_we = 1;
          if (op[8]) begin e.op2_sel = 1; e.imm_sel = 1; end
        end
        2'b10: begin e.alu_en = 1; e.op2_sel = 1; e.imm_sel = 1; e.ale = 1; end
        default: begin
          if (op[7:6] == 2'b00 && cond_true(op[2:0], fl)) begin
            e.pc_sel = 2'd1; e.pc_we = 1;
          end else if (op[7:6] == 2'b01) begin
            e.lr_sel = 1; e.lr_we = 1; e.pc_sel = 2'd1; e.pc_we = 1;
          end else if (op[7:6] == 2'b10) begin
            e.pc_sel = 2'd2; e.pc_we = 1;
          end
        end
      endcase
      push(e, 1'($urandom_range(0, 1)));
      cflag_m = fl[2];
      if (op[9:8] == 2'b10) begin
        for (int k = 0; k <= ((ms >= 15) ? 14 : ms); k++) begin
          e = idle_vec();
          if (!op[7]) begin e.n_oe = 0; e.mem_en = 1; e.wd_sel = 1; end
          else begin e.n_we = 0; e.rw = 1; e.rs1_sel = 1; e.alu_en = 1; end
          if (k == ms) begin
            if (!op[7]) e.reg_we = 1;
            push(e, 1);
          end else push(e, 0);
        end
        if (ms >= 15) pend_err = 1'b1;
      end
    end

    cyc = 0;
    while (exp_q.size() > 0 && (cut == 0 || cyc < cut)) begin
      @(negedge Clock);
      Opcode = op;
      Flags  = fl;
      nWait  = nw_q.pop_front();
      #1;
      check($sformatf("%s c%0d", name, cyc), obs, exp_q.pop_front());
      cyc++;
    end
  endtask

  function automatic int rnd_stall();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return 0;
    if (r < 94) return int'($urandom_range(1, 4));
    if (r < 97) return 14;
    return 15;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ctl_t rv;
    nReset = 1'b0;
    Opcode = '0;
    Flags  = '0;
    nWait  = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    rv = idle_vec();
    check("reset", obs, rv);
    @(posedge Clock);
    #1 nReset = 1'b1;

    run_instr("alu_reg",  10'b00_0101_0000, 4'b0000, 0, 0, 0);
    run_instr("alu_imm",  10'b01_1010_0000, 4'b0100, 0, 0, 0);
    run_instr("ldw_st2",  10'b10_0_0000000, 4'b0000, 0, 2, 0);
    run_instr("stw_st1",  10'b10_1_0000000, 4'b0100, 1, 1, 0);
    run_instr("bz_take",  10'b11_00_000_001, 4'b1000, 0, 0, 0);
    run_instr("bz_skip",  10'b11_00_000_001, 4'b0000, 0, 0, 0);
    run_instr("b_never",  10'b11_00_000_111, 4'b1111, 0, 0, 0);
    run_instr("call",     10'b11_01_000_000, 4'b0000, 0, 0, 0);
    run_instr("ret",      10'b11_10_000_000, 4'b0000, 0, 0, 0);
    run_instr("nop",      10'b11_11_000_000, 4'b0000, 0, 0, 0);
    run_instr("f_to",     10'b00_0001_0000, 4'b0000, 15, 0, 0);
    run_instr("f_14",     10'b00_0001_0000, 4'b0100, 14, 0, 0);
    run_instr("ldw_to",   10'b10_0_0000000, 4'b0000, 0, 15, 0);
    run_instr("stw_to",   10'b10_1_0000000, 4'b0000, 0, 15, 0);
    run_instr("after_to", 10'b11_11_000_000, 4'b0000, 0, 0, 0);

    // Reset asserted while a store holds nWE low.
    run_instr("stw_cut",  10'b10_1_0000000, 4'b0100, 0, 5, 4);
    nReset   = 1'b0;
    cflag_m  = 1'b0;
    pend_err = 1'b0;
    #1;
    rv = idle_vec();
    check("rst_mid", obs, rv);
    @(posedge Clock);
    #1 nReset = 1'b1;
    #1;
    rv = idle_vec(); rv.pc_en = 1; rv.ale = 1;
    check("rst_rel", obs, rv);
    run_instr("post_rst", 10'b00_0011_0000, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      run_instr($sformatf("r%0d", i), 10'($urandom_range(0, 1023)),
                4'($urandom_range(0, 15)), rnd_stall(), rnd_stall(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
